mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS core. Each instruction runs over several clock cycles, and a single shared memory serves both instruction fetch and data access. The block reads the latched opcode/funct and the ALU zero flag from the datapath. It then drives every datapath enable and mux select, one state per cycle, and inserts memory wait states when that feature is compiled in.

---
 rtl/mips_multicycle_ctrl_if.sv | 35 +++
 rtl/mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       iord;
  logic       mem_re;
  logic       mem_we;
  logic       reg_we;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core (shared instruction/data memory).
// Optional feature: define MIPS_CTRL_MEM_WAIT_EN to honour mem_ready wait states;
// otherwise mem_ready is ignored and every memory state lasts one cycle.
module mips_multicycle_ctrl (
  input  logic                          clk,
  input  logic                          rst_n,
  mips_multicycle_ctrl_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  IMMEX  = 4'd9,  IMMWB  = 4'd10, JUMP   = 4'd11,
    JAL    = 4'd12, JR     = 4'd13, HALT   = 4'd14
  } state_t;

  // Registered control word; *_rdy / *_z / *_nz bits are qualified late by
  // mem_ready and zero, which must act in the same cycle.
  typedef struct packed {
    logic       pc_we;
    logic       pc_we_rdy;
    logic       pc_we_z;
    logic       pc_we_nz;
    logic       ir_we_rdy;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       done;
    logic       done_rdy;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                     input logic [5:0] fn, input logic rdy);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:  n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:     n = MEMADR;
          OP_RTYPE: begin
            case (fn)
              FN_JR:                                  n = JR;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  n = EXEC;
              default:                                n = HALT;
            endcase
          end
          OP_BEQ, OP_BNE:   n = BRANCH;
          OP_ADDI, OP_ANDI: n = IMMEX;
          OP_J:             n = JUMP;
          OP_JAL:           n = JAL;
          default:          n = HALT;
        endcase
      end
      MEMADR: n = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  n = rdy ? MEMWB : MEMRD;
      MEMWR:  n = rdy ? FETCH : MEMWR;
      EXEC:   n = ALUWB;
      IMMEX:  n = IMMWB;
      HALT:   n = HALT;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op,
                                    input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_re    = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
        c.ir_we_rdy = 1'b1;
        c.pc_we_rdy = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      MEMRD: begin
        c.mem_re = 1'b1;
        c.iord   = 1'b1;
      end
      MEMWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 2'b01;
        c.done       = 1'b1;
      end
      MEMWR: begin
        c.mem_we   = 1'b1;
        c.iord     = 1'b1;
        c.done_rdy = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        case (fn)
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      ALUWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 2'b01;
        c.done    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
        c.done      = 1'b1;
        c.pc_we_z   = (op == OP_BEQ);
        c.pc_we_nz  = (op != OP_BEQ);
      end
      IMMEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = (op == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      IMMWB: begin
        c.reg_we = 1'b1;
        c.done   = 1'b1;
      end
      JUMP: begin
        c.pc_src = 2'b10;
        c.pc_we  = 1'b1;
        c.done   = 1'b1;
      end
      JAL: begin
        c.reg_we     = 1'b1;
        c.reg_dst    = 2'b10;
        c.mem_to_reg = 2'b10;
        c.pc_src     = 2'b10;
        c.pc_we      = 1'b1;
        c.done       = 1'b1;
      end
      JR: begin
        c.pc_src = 2'b11;
        c.pc_we  = 1'b1;
        c.done   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   illegal_q;
  logic   rdy;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  assign rdy = bus.mem_ready;
`else
  assign rdy = 1'b1;
`endif

  // Next-state decode from the current state, latched instruction and memory status
  always_comb begin
    nxt = next_of(state, bus.opcode, bus.funct, rdy);
  end

  // State register plus control word for the state being entered; illegal is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      ctrl      <= ctrl_of(FETCH, '0, '0);
      illegal_q <= 1'b0;
    end else begin
      state     <= nxt;
      ctrl      <= ctrl_of(nxt, bus.opcode, bus.funct);
      illegal_q <= illegal_q | (nxt == HALT);
    end
  end

  // Control word is preloaded with FETCH so the first fetch can complete on the
  // first edge after reset; rst_n masks it so all outputs read 0 while held in reset.
  always_comb begin
    bus.pc_we      = rst_n & (ctrl.pc_we | (ctrl.pc_we_rdy & rdy) |
                              (ctrl.pc_we_z & bus.zero) | (ctrl.pc_we_nz & ~bus.zero));
    bus.ir_we      = rst_n & ctrl.ir_we_rdy & rdy;
    bus.iord       = rst_n & ctrl.iord;
    bus.mem_re     = rst_n & ctrl.mem_re;
    bus.mem_we     = rst_n & ctrl.mem_we;
    bus.reg_we     = rst_n & ctrl.reg_we;
    bus.reg_dst    = rst_n ? ctrl.reg_dst    : '0;
    bus.mem_to_reg = rst_n ? ctrl.mem_to_reg : '0;
    bus.alu_src_a  = rst_n & ctrl.alu_src_a;
    bus.alu_src_b  = rst_n ? ctrl.alu_src_b  : '0;
    bus.alu_op     = rst_n ? ctrl.alu_op     : '0;
    bus.pc_src     = rst_n ? ctrl.pc_src     : '0;
    bus.instr_done = rst_n & (ctrl.done | (ctrl.done_rdy & rdy));
    bus.illegal    = illegal_q;
    bus.state      = state;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: random instruction streams with
// random wait states and zero flags, checked cycle by cycle against a reference
// built from instruction state paths and the per-state output table.
module tb_mips_multicycle_ctrl;

`ifdef MIPS_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic ill = 1'b0;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] observed();
    return {bus.state, bus.pc_we, bus.ir_we, bus.iord, bus.mem_re, bus.mem_we,
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.instr_done, bus.illegal};
  endfunction

  // Output table indexed by state number, with mem_ready/zero qualification
  function automatic logic [23:0] expected(input int s, input logic [5:0] op,
                                           input logic [5:0] fn, input logic er,
                                           input logic z, input logic il);
    logic [3:0] st;
    logic pw, iw, io, mr, mw, rw, sa, dn;
    logic [1:0] rd, m2r, sb, ps;
    logic [2:0] ao;
    st = 4'(s);
    {pw, iw, io, mr, mw, rw, sa, dn} = '0;
    {rd, m2r, sb, ps} = '0;
    ao = '0;
    case (s)
      0:  begin mr = 1; sb = 2'b01; ao = 3'b010; iw = er; pw = er; end
      1:  begin sb = 2'b11; ao = 3'b010; end
      2:  begin sa = 1; sb = 2'b10; ao = 3'b010; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; dn = 1; end
      5:  begin mw = 1; io = 1; dn = er; end
      6:  begin
            sa = 1;
            case (fn)
              6'b100010: ao = 3'b110;
              6'b100100: ao = 3'b000;
              6'b100101: ao = 3'b001;
              6'b101010: ao = 3'b111;
              default:   ao = 3'b010;
            endcase
          end
      7:  begin rw = 1; rd = 2'b01; dn = 1; end
      8:  begin sa = 1; ao = 3'b110; ps = 2'b01; dn = 1; pw = (op == 6'b000100) ? z : ~z; end
      9:  begin sa = 1; sb = 2'b10; ao = (op == 6'b001000) ? 3'b010 : 3'b000; end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2'b10; pw = 1; dn = 1; end
      12: begin rw = 1; rd = 2'b10; m2r = 2'b10; ps = 2'b10; pw = 1; dn = 1; end
      13: begin ps = 2'b11; pw = 1; dn = 1; end
      default: ;
    endcase
    return {st, pw, iw, io, mr, mw, rw, rd, m2r, sa, sb, ao, ps, dn, il};
  endfunction

  // Runs one instruction: wf/wm = wait cycles in FETCH / data memory state
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned wf, input int unsigned wm, input logic zb,
                           output int unsigned cycles);
    int path[$];
    int s;
    int unsigned nw, reps;
    logic [23:0] e, a;
    case (op)
      6'b100011: path = {0, 1, 2, 3, 4};
      6'b101011: path = {0, 1, 2, 5};
      6'b000000: begin
        if (fn == 6'b001000) path = {0, 1, 13};
        else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          path = {0, 1, 6, 7};
        else path = {0, 1, 14};
      end
      6'b000100, 6'b000101: path = {0, 1, 8};
      6'b001000, 6'b001100: path = {0, 1, 9, 10};
      6'b000010: path = {0, 1, 11};
      6'b000011: path = {0, 1, 12};
      default:   path = {0, 1, 14};
    endcase
    cycles = 0;
    foreach (path[i]) begin
      s = path[i];
      nw = (s == 0) ? wf : ((s == 3 || s == 5) ? wm : 0);
      reps = WAIT_EN ? nw + 1 : 1;
      for (int unsigned k = 0; k < reps; k++) begin
        @(negedge clk);
        if (i == 0 && k == 0) begin
          bus.opcode = op;
          bus.funct  = fn;
        end
        if (s == 0 || s == 3 || s == 5)
          bus.mem_ready = WAIT_EN ? (k == nw) : (nw == 0);
        else
          bus.mem_ready = 1'($urandom);
        bus.zero = (s == 8) ? zb : 1'($urandom);
        if (s == 14) ill = 1'b1;
        #1;
        e = expected(s, op, fn, WAIT_EN ? bus.mem_ready : 1'b1, bus.zero, ill);
        a = observed();
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s state=%0d wait=%0d got=%h exp=%h", name, s, k, a, e);
        end
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'b1;
      bus.zero      = 1'($urandom);
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b100000;
      #1;
      checks++;
      if (observed() !== 24'h0) begin
        failures++;
        $display("FAIL reset_outputs got=%h exp=%h", observed(), 24'h0);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    ill = 1'b0;
  endtask

  task automatic test_rtype();
    int unsigned c;
    run_instr("add", 6'b000000, 6'b100000, 0, 0, 1'b0, c);
    checks++;
    if (c !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", c); end
    run_instr("slt", 6'b000000, 6'b101010, 1, 0, 1'b1, c);
    checks++;
    if (c !== (WAIT_EN ? 5 : 4)) begin failures++; $display("FAIL slt_latency got=%0d", c); end
  endtask

  task automatic test_lw_wait();
    int unsigned c;
    run_instr("lw_wait", 6'b100011, 6'b010101, 0, 2, 1'b0, c);
    checks++;
    if (c !== (WAIT_EN ? 7 : 5)) begin failures++; $display("FAIL lw_latency got=%0d", c); end
  endtask

  task automatic test_branch();
    int unsigned c;
    run_instr("beq_z1", 6'b000100, 6'b000000, 0, 0, 1'b1, c);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL beq_latency got=%0d exp=3", c); end
    run_instr("bne_z1", 6'b000101, 6'b000000, 0, 0, 1'b1, c);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL bne_latency got=%0d exp=3", c); end
    run_instr("beq_z0", 6'b000100, 6'b111111, 0, 0, 1'b0, c);
    run_instr("bne_z0", 6'b000101, 6'b111111, 0, 0, 1'b0, c);
  endtask

  task automatic test_jumps();
    int unsigned c;
    run_instr("jal", 6'b000011, 6'b000000, 0, 0, 1'b0, c);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL jal_latency got=%0d exp=3", c); end
    run_instr("j",  6'b000010, 6'b000000, 0, 0, 1'b0, c);
    run_instr("jr", 6'b000000, 6'b001000, 0, 0, 1'b0, c);
    checks++;
    if (c !== 3) begin failures++; $display("FAIL jr_latency got=%0d exp=3", c); end
  endtask

  task automatic test_imm_sw();
    int unsigned c;
    run_instr("addi", 6'b001000, 6'b000000, 0, 0, 1'b0, c);
    run_instr("andi", 6'b001100, 6'b000000, 0, 0, 1'b0, c);
    checks++;
    if (c !== 4) begin failures++; $display("FAIL andi_latency got=%0d exp=4", c); end
    run_instr("sw_ready_low", 6'b101011, 6'b000000, 1, 1, 1'b0, c);
    checks++;
    if (c !== (WAIT_EN ? 6 : 4)) begin failures++; $display("FAIL sw_latency got=%0d", c); end
  endtask

  task automatic test_illegal(input string name, input logic [5:0] op, input logic [5:0] fn);
    int unsigned c;
    run_instr(name, op, fn, 0, 0, 1'b0, c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom);
      bus.zero      = 1'($urandom);
      bus.opcode    = 6'($urandom);
      #1;
      checks++;
      if (observed() !== expected(14, 6'h3f, 6'h00, 1'b1, 1'b0, 1'b1)) begin
        failures++;
        $display("FAIL %s_hold cyc=%0d got=%h", name, i, observed());
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.illegal !== 1'b0 || bus.state !== 4'd0) begin
      failures++;
      $display("FAIL %s_clear illegal=%b state=%0d exp illegal=0 state=0", name, bus.illegal, bus.state);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    ill = 1'b0;
  endtask

  task automatic test_reset_mid();
    int path[4] = '{0, 1, 2, 5};
    bus.opcode = 6'b101011;
    bus.funct  = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ready = (path[i] != 5);
      bus.zero      = 1'b0;
      #1;
      checks++;
      if (observed() !== expected(path[i], 6'b101011, 6'b000000,
                                  WAIT_EN ? bus.mem_ready : 1'b1, 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL reset_mid_step state=%0d got=%h", path[i], observed());
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid_drop got=%h exp=%h", observed(), 24'h0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[14] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000,
                           6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                           6'b001000, 6'b001100, 6'b000010, 6'b000011};
    logic [5:0] fns[14] = '{6'h00, 6'h00, 6'b100000, 6'b100010, 6'b100100,
                           6'b100101, 6'b101010, 6'b001000, 6'h00, 6'h00,
                           6'h00, 6'h00, 6'h00, 6'h00};
    int unsigned c, idx;
    logic [5:0] fn;
    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(13, 0);
      fn = (ops[idx] == 6'b000000) ? fns[idx] : 6'($urandom);
      run_instr("random", ops[idx], fn, $urandom_range(3, 0), $urandom_range(3, 0),
                1'($urandom), c);
    end
  endtask

  initial begin
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_imm_sw();
    test_illegal("halt_op", 6'b111111, 6'b000000);
    test_illegal("halt_fn", 6'b000000, 6'b000001);
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
